// File: rtl/instruction_uc.sv
// instruction_uc: multi-cycle control unit for a small RV32I-style datapath.
// Each instruction goes through FETCH, DECODE and EXEC. Loads take one more
// cycle, LOAD_WB. An illegal opcode sends the unit to ERROR, which it leaves
// only on reset.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   opcode/funct3/   instruction fields IR[6:0], IR[14:12], IR[30]; sampled
//   funct7_5         only while in DECODE
//   IR_load          instruction register load strobe (FETCH)
//   PC_load          PC update strobe (instruction retires on this edge)
//   WE_reg/WE_mem    register-bank / data-memory write enables
//   OP_MEM_I         operand/writeback path: 0 R, 1 load/store, 2 imm ALU, 3 jump/AUIPC
//   ADD_SUB          ALU add (0) / sub (1)
//   JAL/JALR/AUIPC   next-PC / writeback selects
//   BRANCH           PC_load gated by the flag chosen by select_flags
//   select_flags     branch condition (latched funct3), 0 when not branching
//   error            sticky illegal-opcode indication
//   instr_count      retired instruction count, wraps
//
// state   | meaning
// --------+-----------------------------------------------
// RST     | held in reset, everything quiet
// FETCH   | load IR
// DECODE  | latch instruction class, funct3, funct7_5
// EXEC    | execute from the latched class
// LOAD_WB | load data writeback
// ERROR   | illegal opcode seen, wait for reset
module instruction_uc (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output logic        IR_load,
  output logic        PC_load,
  output logic        WE_reg,
  output logic        WE_mem,
  output logic [1:0]  OP_MEM_I,
  output logic        ADD_SUB,
  output logic        JAL,
  output logic        JALR,
  output logic        AUIPC,
  output logic        BRANCH,
  output logic [2:0]  select_flags,
  output logic        error,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_LOAD_WB, S_ERROR
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_AUIPC
  } cls_t;

  state_t     state, state_nxt;
  cls_t       cls_q, cls_dec;
  logic [2:0] f3_q;
  logic       f7_q;

  always_comb begin
    cls_dec = C_NONE;
    case (opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_I;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b1101111: cls_dec = C_JAL;
      7'b1100111: cls_dec = C_JALR;
      7'b0010111: cls_dec = C_AUIPC;
      default:    cls_dec = C_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  // Instruction fields are captured only on leaving DECODE, so EXEC and
  // LOAD_WB ignore whatever the IR inputs do afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      cls_q <= C_NONE;
      f3_q  <= 3'b000;
      f7_q  <= 1'b0;
    end else if (state == S_DECODE) begin
      cls_q <= cls_dec;
      f3_q  <= funct3;
      f7_q  <= funct7_5;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:     state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = (cls_dec == C_NONE) ? S_ERROR : S_EXEC;
      S_EXEC:    state_nxt = (cls_q == C_LOAD) ? S_LOAD_WB : S_FETCH;
      S_LOAD_WB: state_nxt = S_FETCH;
      S_ERROR:   state_nxt = S_ERROR;
      default:   state_nxt = S_RST;
    endcase
  end

  always_comb begin
    IR_load      = 1'b0;
    PC_load      = 1'b0;
    WE_reg       = 1'b0;
    WE_mem       = 1'b0;
    OP_MEM_I     = 2'd0;
    ADD_SUB      = 1'b0;
    JAL          = 1'b0;
    JALR         = 1'b0;
    AUIPC        = 1'b0;
    BRANCH       = 1'b0;
    select_flags = 3'b000;
    error        = 1'b0;
    case (state)
      S_FETCH:   IR_load = 1'b1;
      S_LOAD_WB: begin
        OP_MEM_I = 2'd1;
        WE_reg   = 1'b1;
        PC_load  = 1'b1;
      end
      S_ERROR:   error = 1'b1;
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            WE_reg  = 1'b1;
            PC_load = 1'b1;
            ADD_SUB = f7_q && (f3_q == 3'b000);
          end
          C_I: begin
            OP_MEM_I = 2'd2;
            WE_reg   = 1'b1;
            PC_load  = 1'b1;
          end
          // Address phase only; writeback happens in LOAD_WB.
          C_LOAD:  OP_MEM_I = 2'd1;
          C_STORE: begin
            OP_MEM_I = 2'd1;
            WE_mem   = 1'b1;
            PC_load  = 1'b1;
          end
          C_BRANCH: begin
            ADD_SUB      = 1'b1;
            BRANCH       = 1'b1;
            select_flags = f3_q;
            PC_load      = 1'b1;
          end
          C_JAL, C_JALR, C_AUIPC: begin
            OP_MEM_I = 2'd3;
            WE_reg   = 1'b1;
            PC_load  = 1'b1;
            JAL      = (cls_q == C_JAL);
            JALR     = (cls_q == C_JALR);
            AUIPC    = (cls_q == C_AUIPC);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)        instr_count <= 32'd0;
    else if (PC_load) instr_count <= instr_count + 32'd1;
  end

endmodule

// File: tb/tb_instruction_uc.sv
module tb_instruction_uc;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        IR_load, PC_load, WE_reg, WE_mem, ADD_SUB, JAL, JALR, AUIPC, BRANCH, error;
  logic [1:0]  OP_MEM_I;
  logic [2:0]  select_flags;
  logic [31:0] instr_count;

  instruction_uc dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .IR_load(IR_load), .PC_load(PC_load), .WE_reg(WE_reg), .WE_mem(WE_mem),
    .OP_MEM_I(OP_MEM_I), .ADD_SUB(ADD_SUB), .JAL(JAL), .JALR(JALR), .AUIPC(AUIPC),
    .BRANCH(BRANCH), .select_flags(select_flags), .error(error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] cnt;
    logic [11:0] outs;
  } rec_t;

  rec_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned next_fetch = 0;
  logic [31:0] model_cnt = 0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111;
  logic [6:0] legal_ops [8] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_AUIPC};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {IR_load, PC_load, error, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, JAL, JALR, AUIPC, BRANCH, select_flags}
  function automatic logic [14:0] all_outs();
    return {IR_load, PC_load, error, WE_reg, WE_mem, OP_MEM_I, ADD_SUB,
            JAL, JALR, AUIPC, BRANCH, select_flags};
  endfunction

  // Reference: what the retiring cycle of an instruction should show.
  // v = {WE_reg, WE_mem, OP_MEM_I, ADD_SUB, JAL, JALR, AUIPC, BRANCH, select_flags}
  function automatic void ref_model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                    output bit legal, output bit is_load, output logic [11:0] v);
    bit we_r = 0, we_m = 0, as = 0, j = 0, jr = 0, au = 0, br = 0;
    logic [1:0] path = 2'd0;
    logic [2:0] sf = 3'd0;
    legal = 1; is_load = 0;
    case (op)
      OP_R:     begin we_r = 1; as = f7 && (f3 == 3'd0); end
      OP_I:     begin path = 2; we_r = 1; end
      OP_LD:    begin path = 1; we_r = 1; is_load = 1; end
      OP_ST:    begin path = 1; we_m = 1; end
      OP_BR:    begin as = 1; br = 1; sf = f3; end
      OP_JAL:   begin path = 3; we_r = 1; j = 1; end
      OP_JALR:  begin path = 3; we_r = 1; jr = 1; end
      OP_AUIPC: begin path = 3; we_r = 1; au = 1; end
      default:  legal = 0;
    endcase
    v = {we_r, we_m, path, as, j, jr, au, br, sf};
  endfunction

  task automatic drive_junk();
    opcode   = 7'($urandom);
    funct3   = 3'($urandom);
    funct7_5 = 1'($urandom);
  endtask

  // Monitor: every retirement (PC_load) must match the next scoreboard entry.
  always @(negedge clk) begin
    rec_t r;
    chk("we_exclusive", {63'd0, WE_reg & WE_mem}, 64'd0);
    chk("sel_without_branch", {61'd0, (BRANCH ? 3'd0 : select_flags)}, 64'd0);
    chk("select_onehot", {63'd0, ($countones({JAL, JALR, AUIPC, BRANCH}) <= 1)}, 64'd1);
    if (PC_load) begin
      if (sb.size() == 0) chk("unexpected_retire", 64'd1, 64'd0);
      else begin
        r = sb.pop_front();
        chk("retire_cycle", 64'(cyc), 64'(r.cyc));
        chk("retire_outputs", {52'd0, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, JAL, JALR, AUIPC,
                               BRANCH, select_flags}, {52'd0, r.outs});
        chk("retire_count", {32'd0, instr_count}, {32'd0, r.cnt});
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    chk("reset_outputs", {49'd0, all_outs()}, 64'd0);
    chk("reset_count", {32'd0, instr_count}, 64'd0);
    reset = 1'b0;
    model_cnt = 0;
    next_fetch = cyc + 1;
  endtask

  // Enters at a negedge; returns at the negedge of EXEC (or ERROR).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7, input bit preload);
    int n = 0;
    int unsigned fc;
    bit legal, ld;
    logic [11:0] v;
    rec_t r;
    while (!IR_load && n < 10) begin @(negedge clk); n++; end
    if (!IR_load) begin chk("fetch_timeout", 64'd0, 64'd1); return; end
    fc = cyc;
    chk("fetch_cycle", 64'(fc), 64'(next_fetch));
    chk("fetch_outputs", {49'd0, all_outs()}, 64'h4000);
    drive_junk();
    @(negedge clk);
    chk("decode_outputs", {49'd0, all_outs()}, 64'd0);
    opcode = op; funct3 = f3; funct7_5 = f7;
    ref_model(op, f3, f7, legal, ld, v);
    if (preload) begin
      force dut.instr_count = 32'hFFFF_FFFF;
      #1;
      release dut.instr_count;
      model_cnt = 32'hFFFF_FFFF;
    end
    if (legal) begin
      r.cyc = fc + (ld ? 3 : 2);
      r.cnt = model_cnt;
      r.outs = v;
      sb.push_back(r);
      model_cnt = model_cnt + 1;
      next_fetch = fc + (ld ? 4 : 3);
    end
    @(negedge clk);
    drive_junk();
    if (legal && ld) chk("load_addr_phase", {49'd0, all_outs()}, 64'h0100);
  endtask

  initial begin
    logic [6:0] op;
    bit lg, ld;
    logic [11:0] v;
    reset = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    do_reset(2);

    // Directed: SUB, load, then store/branch/jumps
    issue(OP_R, 3'b000, 1'b1, 0);
    issue(OP_LD, 3'b010, 1'b0, 0);
    issue(OP_ST, 3'b010, 1'b0, 0);
    issue(OP_BR, 3'b000, 1'b0, 0);
    issue(OP_JAL, 3'b000, 1'b0, 0);
    issue(OP_JALR, 3'b000, 1'b0, 0);
    issue(OP_AUIPC, 3'b000, 1'b0, 0);

    // Counter wrap
    issue(OP_R, 3'b000, 1'b0, 1);
    @(negedge clk);
    chk("count_wrapped", {32'd0, instr_count}, 64'd0);
    issue(OP_I, 3'b001, 1'b1, 0);

    // Randomized legal instructions
    for (int i = 0; i < 60; i++) begin
      logic [6:0] rop;
      logic [2:0] rf3;
      logic rf7;
      rop = legal_ops[$urandom_range(0, 7)];
      rf3 = 3'($urandom);
      rf7 = 1'($urandom);
      if (rop == OP_R && $urandom_range(0, 1) == 1) begin rf3 = 3'd0; rf7 = 1'b1; end
      issue(rop, rf3, rf7, 0);
    end

    // Reset in the EXEC cycle of a store
    issue(OP_ST, 3'b000, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("store_reset_we_mem", {63'd0, WE_mem}, 64'd0);
    chk("store_reset_count", {32'd0, instr_count}, 64'd0);
    do_reset(1);
    issue(OP_I, 3'b000, 1'b0, 0);

    // Illegal opcodes
    for (int k = 0; k < 2; k++) begin
      if (k == 0) op = 7'b1111111;
      else begin
        do begin
          op = 7'($urandom);
          ref_model(op, 3'd0, 1'b0, lg, ld, v);
        end while (lg);
      end
      issue(op, 3'($urandom), 1'($urandom), 0);
      for (int c = 0; c < 10; c++) begin
        chk("error_state", {49'd0, all_outs()}, 64'h1000);
        @(negedge clk);
        drive_junk();
      end
      do_reset(2);
      issue(OP_BR, 3'($urandom), 1'b0, 0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_uc.md
INSTRUCTION_UC -- requirements
Module: instruction_uc

Interface
REQ-001 The clock SHALL be clk, input, 1 bit; all state changes occur on its rising edge.
REQ-002 The reset SHALL be reset, input, 1 bit: synchronous and active-high.
REQ-003 opcode SHALL be an input, 7 bits, carrying the instruction opcode (IR[6:0]).
REQ-004 funct3 SHALL be an input, 3 bits, carrying IR[14:12].
REQ-005 funct7_5 SHALL be an input, 1 bit, carrying IR[30].
REQ-006 IR_load SHALL be an output, 1 bit: instruction register load strobe.
REQ-007 PC_load SHALL be an output, 1 bit: PC update strobe.
REQ-008 WE_reg SHALL be an output, 1 bit: register-bank write enable.
REQ-009 WE_mem SHALL be an output, 1 bit: data-memory write enable.
REQ-010 OP_MEM_I SHALL be an output, 2 bits, selecting the operand/writeback path: 0 = R-type, 1 = load/store, 2 = immediate ALU, 3 = jump/AUIPC.
REQ-011 ADD_SUB SHALL be an output, 1 bit: ALU select, 0 = add, 1 = sub.
REQ-012 JAL, JALR and AUIPC SHALL each be an output, 1 bit: next-PC/writeback selects.
REQ-013 BRANCH SHALL be an output, 1 bit: PC_load is conditioned on the flag selected by select_flags.
REQ-014 select_flags SHALL be an output, 3 bits: branch condition, equal to latched funct3.
REQ-015 error SHALL be an output, 1 bit: sticky illegal-opcode indication.
REQ-016 instr_count SHALL be an output, 32 bits: count of retired instructions.

Function
REQ-017 The FSM SHALL have exactly these states: RST, FETCH, DECODE, EXEC, LOAD_WB, ERROR.
REQ-018 State transitions SHALL be: RST->FETCH; FETCH->DECODE; DECODE->EXEC for a legal opcode, else DECODE->ERROR; EXEC->LOAD_WB for a load, else EXEC->FETCH; LOAD_WB->FETCH; ERROR->ERROR.
REQ-019 In DECODE the block SHALL latch the instruction class, funct3 and funct7_5; outputs in EXEC and LOAD_WB SHALL depend only on the latched values.
REQ-020 Legal opcodes SHALL be: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111.
REQ-021 In FETCH: IR_load=1; all other strobes 0.
REQ-022 In DECODE: all strobes 0.
REQ-023 In EXEC for R: OP_MEM_I=0, WE_reg=1, PC_load=1, ADD_SUB=1 only when funct7_5=1 and funct3=000, otherwise ADD_SUB=0.
REQ-024 In EXEC for I-ALU: OP_MEM_I=2, WE_reg=1, PC_load=1, ADD_SUB=0.
REQ-025 In EXEC for LOAD: OP_MEM_I=1 and all strobes 0 (address phase).
REQ-026 In LOAD_WB: OP_MEM_I=1, WE_reg=1, PC_load=1.
REQ-027 In EXEC for STORE: OP_MEM_I=1, WE_mem=1, PC_load=1, WE_reg=0.
REQ-028 In EXEC for BRANCH: OP_MEM_I=0, ADD_SUB=1, BRANCH=1, select_flags=funct3, PC_load=1, WE_reg=0.
REQ-029 In EXEC for JAL, JALR or AUIPC: OP_MEM_I=3, WE_reg=1, PC_load=1, and only the matching select among JAL/JALR/AUIPC asserted.
REQ-030 select_flags SHALL be 000 whenever BRANCH=0.
REQ-031 JAL, JALR, AUIPC and BRANCH SHALL be mutually exclusive.
REQ-032 WE_reg and WE_mem SHALL never both be 1.
REQ-033 Latency SHALL be 3 cycles per instruction (FETCH, DECODE, EXEC), and 4 cycles for loads.
REQ-034 instr_count SHALL increment by 1 on each edge where PC_load=1, wrapping from 0xFFFFFFFF to 0.
REQ-035 In ERROR: error=1 and all strobes 0; the state SHALL be left only by reset.
REQ-036 Opcode changes outside DECODE SHALL have no effect.

Reset
REQ-037 reset=1 at a rising edge SHALL force RST from any state, including mid-instruction and ERROR; it SHALL take priority over every transition.
REQ-038 In RST: all outputs 0, error=0, instr_count=0, latched class cleared.
REQ-039 A strobe asserted in the cycle that reset is sampled SHALL be deasserted from the next cycle.

Verification
REQ-040 Reset 2 cycles, then opcode=0110011, funct3=000, funct7_5=1 -> IR_load=1 in cycle 1; cycle 3: WE_reg=1, PC_load=1, ADD_SUB=1, OP_MEM_I=0; instr_count=1.
REQ-041 LOAD 0000011 -> EXEC with all strobes 0, then LOAD_WB with WE_reg=1, PC_load=1, OP_MEM_I=1; next FETCH at cycle 5.
REQ-042 Sequence STORE, BRANCH (funct3=000), JAL, JALR, AUIPC -> STORE: WE_mem=1, WE_reg=0; BRANCH: BRANCH=1, select_flags=000, ADD_SUB=1; JAL/JALR/AUIPC: one-hot selects with OP_MEM_I=3; instr_count=5 after 15 cycles.
REQ-043 opcode=1111111 -> error=1 from the cycle after DECODE, all strobes 0 for 10 cycles; reset -> error=0, FETCH follows.
REQ-044 reset asserted during EXEC of a STORE -> WE_mem=0 in the next cycle, instr_count=0.
REQ-045 Preload instr_count=0xFFFFFFFF via force, retire one instruction -> instr_count=0.
